// File: rtl/decode_if.sv
// Handshake and decoded-field bundle between fetch, decode and execute.
// slave = decode stage view; master = upstream/downstream environment view.
interface decode_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instruction;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  alu_operation;
    logic        alu_immediate_enable;
    logic [31:0] immediate_data;
    logic [4:0]  shamt;
    logic        shamt_from_register;
    logic [4:0]  register_read_addr_a;
    logic [4:0]  register_read_addr_b;
    logic [4:0]  register_write_addr;
    logic        register_write_enable;
    logic        illegal_instruction;

    modport slave (
        input  in_valid, in_instruction, out_ready,
        output in_ready, out_valid, alu_operation, alu_immediate_enable,
               immediate_data, shamt, shamt_from_register,
               register_read_addr_a, register_read_addr_b,
               register_write_addr, register_write_enable, illegal_instruction
    );

    modport master (
        output in_valid, in_instruction, out_ready,
        input  in_ready, out_valid, alu_operation, alu_immediate_enable,
               immediate_data, shamt, shamt_from_register,
               register_read_addr_a, register_read_addr_b,
               register_write_addr, register_write_enable, illegal_instruction
    );
endinterface

// File: rtl/decode_stage.sv
// RV32I OP / OP-IMM / LUI decoder with a single registered output slot
// and valid/ready handshake on both sides (full throughput, 1 cycle latency).
module decode_stage #(
    parameter bit ENABLE_LUI = 1'b1
) (
    input  logic    clk,
    input  logic    reset,
    decode_if.slave bus
);
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;

    localparam logic [3:0] ALU_ADD  = 4'b0000, ALU_SUB = 4'b0001, ALU_SLL = 4'b0010,
                           ALU_SLT  = 4'b0011, ALU_SLTU = 4'b0100, ALU_XOR = 4'b0101,
                           ALU_SRA  = 4'b0110, ALU_SRL = 4'b0111, ALU_OR  = 4'b1000,
                           ALU_AND  = 4'b1001;

    typedef struct packed {
        logic [3:0]  op;
        logic        imm_en;
        logic [31:0] imm;
        logic [4:0]  shamt;
        logic        sfr;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } dec_t;

    logic        r_valid;
    dec_t        r_out;
    dec_t        w_dec;
    logic        w_legal;
    logic        w_accept;
    logic [31:0] w_instr;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;

    assign w_instr  = bus.in_instruction;
    assign w_f3     = w_instr[14:12];
    assign w_f7     = w_instr[31:25];
    assign w_accept = bus.in_valid && bus.in_ready;

    // Shared funct3 -> ALU op map for the register-register and immediate forms
    function automatic logic [3:0] f3_op(input logic [2:0] f3);
        case (f3)
            3'b000:  f3_op = ALU_ADD;
            3'b001:  f3_op = ALU_SLL;
            3'b010:  f3_op = ALU_SLT;
            3'b011:  f3_op = ALU_SLTU;
            3'b100:  f3_op = ALU_XOR;
            3'b101:  f3_op = ALU_SRL;
            3'b110:  f3_op = ALU_OR;
            default: f3_op = ALU_AND;
        endcase
    endfunction

    always_comb begin
        w_dec   = '0;
        w_legal = 1'b0;
        w_dec.ra = w_instr[19:15];
        w_dec.rb = w_instr[24:20];
        w_dec.rd = w_instr[11:7];
        case (w_instr[6:0])
            OPC_OP: begin
                if (w_f7 == 7'b0000000) begin
                    w_legal  = 1'b1;
                    w_dec.op = f3_op(w_f3);
                end else if (w_f7 == 7'b0100000 && w_f3 == 3'b000) begin
                    w_legal  = 1'b1;
                    w_dec.op = ALU_SUB;
                end else if (w_f7 == 7'b0100000 && w_f3 == 3'b101) begin
                    w_legal  = 1'b1;
                    w_dec.op = ALU_SRA;
                end
                w_dec.sfr = w_legal &&
                            (w_dec.op == ALU_SLL || w_dec.op == ALU_SRL || w_dec.op == ALU_SRA);
            end
            OPC_OPIMM: begin
                if (w_f3 == 3'b001 || w_f3 == 3'b101) begin
                    if (w_f7 == 7'b0000000) begin
                        w_legal  = 1'b1;
                        w_dec.op = f3_op(w_f3);
                    end else if (w_f7 == 7'b0100000 && w_f3 == 3'b101) begin
                        w_legal  = 1'b1;
                        w_dec.op = ALU_SRA;
                    end
                    if (w_legal) w_dec.shamt = w_instr[24:20];
                end else begin
                    w_legal  = 1'b1;
                    w_dec.op = f3_op(w_f3);
                end
                if (w_legal) begin
                    w_dec.imm_en = 1'b1;
                    w_dec.imm    = {{20{w_instr[31]}}, w_instr[31:20]};
                end
            end
            OPC_LUI: begin
                if (ENABLE_LUI) begin
                    w_legal      = 1'b1;
                    w_dec.op     = ALU_ADD;
                    w_dec.ra     = 5'd0;
                    w_dec.imm_en = 1'b1;
                    w_dec.imm    = {w_instr[31:12], 12'b0};
                end
            end
            default: ;
        endcase
        w_dec.ill = !w_legal;
        w_dec.we  = w_legal && (w_dec.rd != 5'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_out   <= '0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_out   <= w_dec;
        end else if (bus.out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.in_ready              = !reset && (!r_valid || bus.out_ready);
    assign bus.out_valid             = r_valid;
    assign bus.alu_operation         = r_out.op;
    assign bus.alu_immediate_enable  = r_out.imm_en;
    assign bus.immediate_data        = r_out.imm;
    assign bus.shamt                 = r_out.shamt;
    assign bus.shamt_from_register   = r_out.sfr;
    assign bus.register_read_addr_a  = r_out.ra;
    assign bus.register_read_addr_b  = r_out.rb;
    assign bus.register_write_addr   = r_out.rd;
    assign bus.register_write_enable = r_out.we;
    assign bus.illegal_instruction   = r_out.ill;
endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: accepted words are decoded by a rule-level
// model into a queue; an independent monitor pops and compares on each transfer out.
module tb_decode_stage;
    logic clk;
    logic reset;
    decode_if dif();

    decode_stage #(.ENABLE_LUI(1'b1)) dut (.clk(clk), .reset(reset), .bus(dif));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0]  op;
        logic        imm_en;
        logic [31:0] imm;
        logic [4:0]  shamt;
        logic        sfr;
        logic [4:0]  a, b, rd;
        logic        we, ill;
        logic        imm_care, ab_care;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] op, input logic imm_en, input logic [31:0] imm,
                                input logic [4:0] shamt, input logic sfr, input logic [4:0] a,
                                input logic [4:0] b, input logic [4:0] rd, input logic we,
                                input logic ill, input logic imm_care, input logic ab_care);
        exp_t e;
        e.op = op; e.imm_en = imm_en; e.imm = imm; e.shamt = shamt; e.sfr = sfr;
        e.a = a; e.b = b; e.rd = rd; e.we = we; e.ill = ill;
        e.imm_care = imm_care; e.ab_care = ab_care;
        return e;
    endfunction

    // Reference decode written straight from the instruction-set rules
    function automatic exp_t model(input logic [31:0] w);
        int   op_of_f3[8] = '{0, 2, 3, 4, 5, 7, 8, 9};
        exp_t e = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        logic [2:0] f3 = w[14:12];
        logic [6:0] f7 = w[31:25];
        bit legal = 0;
        if (w[6:0] == 7'h33) begin
            e.imm_care = 0;
            if (f7 == 0) begin legal = 1; e.op = 4'(op_of_f3[f3]); end
            else if (f7 == 7'h20 && f3 == 0) begin legal = 1; e.op = 1; end
            else if (f7 == 7'h20 && f3 == 5) begin legal = 1; e.op = 6; end
            if (legal) e.sfr = (e.op == 2 || e.op == 7 || e.op == 6);
        end else if (w[6:0] == 7'h13) begin
            if (f3 == 1 || f3 == 5) begin
                e.imm_care = 0;
                if (f7 == 0) begin legal = 1; e.op = 4'(op_of_f3[f3]); end
                else if (f3 == 5 && f7 == 7'h20) begin legal = 1; e.op = 6; end
                if (legal) e.shamt = w[24:20];
                else e.imm_care = 1;
            end else begin
                legal = 1; e.op = 4'(op_of_f3[f3]); e.imm = 32'($signed(w[31:20]));
            end
            if (legal) e.imm_en = 1;
        end else if (w[6:0] == 7'h37) begin
            legal = 1; e.imm_en = 1; e.imm = w & 32'hFFFFF000;
        end
        if (legal) begin
            e.ill = 0; e.ab_care = 1;
            e.a  = (w[6:0] == 7'h37) ? 5'd0 : w[19:15];
            e.b  = w[24:20];
            e.rd = w[11:7];
            e.we = (w[11:7] != 0);
        end
        return e;
    endfunction

    function automatic logic [31:0] gen();
        logic [31:0] w;
        int k;
        w = $urandom;
        k = $urandom_range(0, 7);
        case (k)
            0: begin w[6:0] = 7'h33; w[31:25] = 7'h00; end
            1: begin w[6:0] = 7'h33; w[31:25] = 7'h20; end
            2: w[6:0] = 7'h13;
            3: begin
                w[6:0] = 7'h13; w[13:12] = 2'b01;
                if ($urandom_range(0, 2) == 0) w[31:25] = 7'h00;
                else if ($urandom_range(0, 1) == 0) w[31:25] = 7'h20;
            end
            4: w[6:0] = 7'h37;
            5: ;
            6: w[6:0] = 7'h33;
            default: w = ($urandom_range(0, 1) == 1) ? 32'hFFFFFFFF : 32'h00000013;
        endcase
        return w;
    endfunction

    function automatic logic [59:0] snap();
        return {dif.alu_operation, dif.alu_immediate_enable, dif.immediate_data, dif.shamt,
                dif.shamt_from_register, dif.register_read_addr_a, dif.register_read_addr_b,
                dif.register_write_addr, dif.register_write_enable, dif.illegal_instruction};
    endfunction

    task automatic check_entry(input string tag, input exp_t e);
        cmp({tag, ".op"},  dif.alu_operation, e.op);
        cmp({tag, ".imm_en"}, dif.alu_immediate_enable, e.imm_en);
        cmp({tag, ".shamt"}, dif.shamt, e.shamt);
        cmp({tag, ".sfr"}, dif.shamt_from_register, e.sfr);
        cmp({tag, ".we"},  dif.register_write_enable, e.we);
        cmp({tag, ".ill"}, dif.illegal_instruction, e.ill);
        if (e.imm_care) cmp({tag, ".imm"}, dif.immediate_data, e.imm);
        if (e.ab_care) begin
            cmp({tag, ".ra"}, dif.register_read_addr_a, e.a);
            cmp({tag, ".rb"}, dif.register_read_addr_b, e.b);
            cmp({tag, ".rd"}, dif.register_write_addr, e.rd);
        end
    endtask

    // Stimulus side of the scoreboard: record every accepted word
    always @(negedge clk) begin
        if (!reset && dif.in_valid && dif.in_ready) exp_q.push_back(model(dif.in_instruction));
    end

    // Monitor: handshake rule, stall stability, and in-order comparison on transfer out
    logic        held = 0;
    logic [59:0] held_val;
    always @(negedge clk) begin
        if (reset) begin
            held <= 0;
        end else begin
            cmp("in_ready_rule", dif.in_ready, !dif.out_valid || dif.out_ready);
            if (held) cmp("stall_stable", snap(), held_val);
            if (dif.out_valid && dif.out_ready) begin
                if (exp_q.size() == 0) cmp("unexpected_out", 1, 0);
                else check_entry("sb", exp_q.pop_front());
            end
            held     <= dif.out_valid && !dif.out_ready;
            held_val <= snap();
        end
    end

    task automatic send(input logic [31:0] w);
        int n = 0;
        dif.in_valid = 1; dif.in_instruction = w;
        @(negedge clk);
        while (!dif.in_ready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) cmp("send_timeout", 1, 0);
        @(posedge clk); #1;
        dif.in_valid = 0;
    endtask

    task automatic dchk(input string nm, input logic [31:0] w, input exp_t e);
        dif.out_ready = 1;
        send(w);
        @(negedge clk);
        cmp({nm, ".out_valid"}, dif.out_valid, 1);
        check_entry(nm, e);
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1; dif.in_valid = 0; dif.in_instruction = 0; dif.out_ready = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        cmp("rst.out_valid", dif.out_valid, 0);
        cmp("rst.in_ready", dif.in_ready, 0);
        cmp("rst.data", snap(), 0);
        @(posedge clk); #1;
        reset = 0;
        dif.in_valid = 1; dif.in_instruction = 32'h002081B3; dif.out_ready = 1;
        @(negedge clk);
        cmp("first_accept", dif.in_ready, 1);
        @(posedge clk); #1;
        dif.in_valid = 0;
        @(negedge clk);
        cmp("add.out_valid", dif.out_valid, 1);
        check_entry("add", mk(0, 0, 0, 0, 0, 1, 2, 3, 1, 0, 0, 1));
        @(posedge clk); #1;

        dchk("addi", 32'hFFF00293, mk(0, 1, 32'hFFFFFFFF, 0, 0, 0, 31, 5, 1, 0, 1, 1));
        dchk("srai", 32'h4030D093, mk(6, 1, 0, 3, 0, 1, 3, 1, 1, 0, 0, 1));
        dchk("sub",  32'h40210133, mk(1, 0, 0, 0, 0, 2, 2, 2, 1, 0, 0, 1));
        dchk("sll",  32'h002090B3, mk(2, 0, 0, 0, 1, 1, 2, 1, 1, 0, 0, 1));
        dchk("ill",  32'hFFFFFFFF, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        dchk("nop",  32'h00000013, mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        dchk("lui",  32'h123453B7, mk(0, 1, 32'h12345000, 0, 0, 0, 3, 7, 1, 0, 1, 1));
        dchk("slli_bad", 32'h4030D093 ^ 32'h00004000, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));

        // Backpressure: downstream stalls while upstream keeps offering
        dif.out_ready = 0;
        send(gen());
        dif.in_valid = 1; dif.in_instruction = gen();
        repeat (3) begin
            @(negedge clk);
            cmp("bp.in_ready", dif.in_ready, 0);
            cmp("bp.out_valid", dif.out_valid, 1);
        end
        @(posedge clk); #1;
        dif.out_ready = 1;
        @(posedge clk); #1;
        dif.in_instruction = gen();
        @(posedge clk); #1;
        dif.in_valid = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset during a stall drops the held entry
        dif.out_ready = 0;
        send(gen());
        @(negedge clk);
        cmp("rs.stalled", dif.out_valid, 1);
        @(posedge clk); #1;
        reset = 1;
        @(posedge clk); #1;
        exp_q.delete();
        @(negedge clk);
        cmp("rs.out_valid", dif.out_valid, 0);
        cmp("rs.data", snap(), 0);
        cmp("rs.in_ready_in_reset", dif.in_ready, 0);
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        cmp("rs.in_ready_after", dif.in_ready, 1);
        cmp("rs.no_out", dif.out_valid, 0);
        @(posedge clk); #1;

        // Random traffic with random backpressure
        for (int i = 0; i < 1500; i++) begin
            dif.in_valid       = ($urandom_range(0, 3) != 0);
            dif.in_instruction = gen();
            dif.out_ready      = ($urandom_range(0, 2) != 0);
            @(posedge clk); #1;
        end
        dif.in_valid = 0; dif.out_ready = 1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        cmp("drain.q_empty", exp_q.size(), 0);
        cmp("drain.out_valid", dif.out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter: ENABLE_LUI, default 1, 1 = decode LUI (opcode 0110111) as ADD x0+imm, 0 = flag it illegal.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  upstream instruction word valid.
REQ-005 in_ready  output  1  stage accepts an instruction this cycle.
REQ-006 in_instruction  input  32  RV32I instruction word.
REQ-007 out_valid  output  1  decoded fields below are valid.
REQ-008 out_ready  input  1  ALU/execute side consumes the decoded entry this cycle.
REQ-009 alu_operation  output  4  ALU opcode: add 0000, sub 0001, sll 0010, slt 0011, sltu 0100, xor 0101, sra 0110, srl 0111, or 1000, and 1001.
REQ-010 alu_immediate_enable  output  1  ALU second operand = immediate_data.
REQ-011 immediate_data  output  32  sign-extended or upper immediate.
REQ-012 shamt  output  5  shift amount for immediate shifts (instr[24:20]).
REQ-013 shamt_from_register  output  1  register shift; execute uses rs2 data[4:0] as shift amount.
REQ-014 register_read_addr_a / register_read_addr_b  output  5 each  rs1 / rs2 indices.
REQ-015 register_write_addr  output  5  rd index.
REQ-016 register_write_enable  output  1  rd written on retire.
REQ-017 illegal_instruction  output  1  entry is not a supported OP / OP-IMM / LUI.

Function
REQ-018 in_ready SHALL equal (!out_valid || out_ready) when reset is low, and 0 while reset is high.
REQ-019 Transfer in occurs when in_valid && in_ready; decoded fields and out_valid=1 SHALL appear on the following cycle (latency 1).
REQ-020 Transfer out occurs when out_valid && out_ready; with no simultaneous transfer in, out_valid SHALL drop to 0 next cycle.
REQ-021 Simultaneous transfer out and transfer in SHALL replace the entry with no bubble (full throughput 1/cycle).
REQ-022 While out_valid && !out_ready all outputs SHALL be held bit-stable.
REQ-023 OP (0110011): funct7 0000000 with funct3 000/001/010/011/100/101/110/111 -> add/sll/slt/sltu/xor/srl/or/and; funct7 0100000 with funct3 000/101 -> sub/sra; alu_immediate_enable=0; shamt_from_register=1 for sll/srl/sra else 0.
REQ-024 OP-IMM (0010011): funct3 000/010/011/100/110/111 -> add/slt/sltu/xor/or/and with immediate_data = sign-extend instr[31:20]; alu_immediate_enable=1.
REQ-025 OP-IMM shifts: funct3 001 needs instr[31:25]=0000000 (sll); funct3 101 needs 0000000 (srl) or 0100000 (sra); shamt=instr[24:20], shamt_from_register=0; other funct7 -> illegal.
REQ-026 LUI (ENABLE_LUI=1): alu_operation add, register_read_addr_a=0, immediate_data={instr[31:12],12'b0}, alu_immediate_enable=1.
REQ-027 Register address outputs SHALL be copied from instr[19:15], [24:20], [11:7] for every decoded format except the LUI rs1 override.
REQ-028 register_write_enable SHALL be 1 only for legal instructions with rd != 0.
REQ-029 Illegal encoding: illegal_instruction=1, register_write_enable=0, alu_operation=0000, alu_immediate_enable=0, immediate_data=0; entry still handshaked normally.
REQ-030 shamt SHALL be 0 whenever the entry is not an immediate shift.

Reset
REQ-031 While reset is high at a rising edge: out_valid=0, all data outputs=0 on the next cycle.
REQ-032 Reset asserted mid-stall SHALL discard the held entry; no transfer out is signalled after it.
REQ-033 First acceptance SHALL be possible on the first cycle after reset deasserts.

Verification
REQ-034 ADD x3,x1,x2 (0x002081B3), out_ready=1 -> next cycle out_valid=1, op 0000, imm_en 0, a=1, b=2, rd=3, we=1.
REQ-035 ADDI x5,x0,-1 (0xFFF00293) -> op 0000, imm_en 1, immediate_data 0xFFFFFFFF, a=0, rd=5, we=1.
REQ-036 SRAI x1,x1,3 (0x4030D093) -> op 0110, shamt 3, shamt_from_register 0, imm_en 1; SUB x2,x2,x2 -> op 0001.
REQ-037 Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable; out_ready=1 -> back-to-back entries, no loss/duplication.
REQ-038 0xFFFFFFFF -> illegal_instruction=1, we=0, op 0000; ADDI x0,x0,0 -> legal, we=0.
REQ-039 Reset pulsed while out_valid=1 and out_ready=0 -> out_valid=0 next cycle, in_ready=1 after release.
